// File: rtl/booth_mult_sequencer.sv
// booth_mult_sequencer
//   Sequential radix-2 Booth signed multiplier shared by two requesters
//   through a round-robin arbiter. One Booth step per clock, so a
//   WIDTH x WIDTH product completes WIDTH cycles after the operands
//   are accepted. The 2*WIDTH-bit result is held until the consumer
//   takes it.
//
//   Optional build macro: ZERO_BYPASS_EN
//     When defined, an operation whose multiplicand or multiplier is
//     zero skips the Booth iterations and returns 0 one cycle after
//     accept. When undefined, every operation runs all WIDTH steps.
module booth_mult_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic [WIDTH-1:0]   req0_mc,
    input  logic [WIDTH-1:0]   req0_mp,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [WIDTH-1:0]   req1_mc,
    input  logic [WIDTH-1:0]   req1_mp,
    output logic               req1_ready,
    output logic               rsp_valid,
    output logic [2*WIDTH-1:0] rsp_y,
    output logic               rsp_id,
    input  logic               rsp_ready,
    output logic               busy
);

    // Step counter only has to reach WIDTH-1
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d;          // accumulator, one guard bit
    logic [WIDTH-1:0]     q_q, q_d;          // multiplier / low product half
    logic                 q1_q, q1_d;        // Booth look-behind bit
    logic [WIDTH-1:0]     m_q, m_d;          // latched multiplicand
    logic [CW-1:0]        cnt_q, cnt_d;      // Booth steps already done
    logic                 last_q, last_d;    // requester granted most recently
    logic                 rsp_valid_q, rsp_valid_d;
    logic [2*WIDTH-1:0]   rsp_y_q, rsp_y_d;
    logic                 rsp_id_q, rsp_id_d;

    // Requesters packed into vectors so arbitration is written once
    logic [1:0]              req_valid;
    logic [1:0][WIDTH-1:0]   req_mc_vec;
    logic [1:0][WIDTH-1:0]   req_mp_vec;
    logic [1:0]              grant;
    logic                    accept;
    logic                    accept_id;
    logic [WIDTH-1:0]        sel_mc;
    logic [WIDTH-1:0]        sel_mp;

    // Booth step datapath
    logic [WIDTH:0]       m_ext;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       a_shift;
    logic [WIDTH-1:0]     q_shift;
    logic                 q1_shift;
    logic                 last_step;

    // High when the current RUN cycle should finish without iterating
    logic                 bypass;

    assign req_valid  = {req1_valid, req0_valid};
    assign req_mc_vec = {req1_mc, req0_mc};
    assign req_mp_vec = {req1_mp, req0_mp};

    // Round-robin grant: a lone requester always wins; on a tie the one
    // not granted last time wins. Only offered while idle.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = (state_q == ST_IDLE) && req_valid[gi] &&
                               (!req_valid[1-gi] || (last_q != 1'(gi)));
        end
    endgenerate

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accept     = |grant;
    assign accept_id  = grant[1];
    assign sel_mc     = req_mc_vec[accept_id];
    assign sel_mp     = req_mp_vec[accept_id];

`ifdef ZERO_BYPASS_EN
    // Zero-operand flag captured at accept; consumed in the single RUN cycle
    logic zero_q, zero_d;

    // Zero-operand flag register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    // Flag is refreshed on every accept and otherwise held
    always_comb begin
        zero_d = zero_q;
        if (accept) begin
            zero_d = (sel_mc == '0) || (sel_mp == '0);
        end
    end

    assign bypass = zero_q;
`else
    assign bypass = 1'b0;
`endif

    // One radix-2 Booth step: conditional add/subtract then arithmetic shift
    always_comb begin
        m_ext = {m_q[WIDTH-1], m_q};
        case ({q_q[0], q1_q})
            2'b01:   sum = a_q + m_ext;
            2'b10:   sum = a_q - m_ext;
            default: sum = a_q;
        endcase
        a_shift   = {sum[WIDTH], sum[WIDTH:1]};
        q_shift   = {sum[0], q_q[WIDTH-1:1]};
        q1_shift  = q_q[0];
        last_step = (cnt_q == CW'(WIDTH - 1));
    end

    // FSM next-state and datapath register updates
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        q_d         = q_q;
        q1_d        = q1_q;
        m_d         = m_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        rsp_id_d    = rsp_id_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    m_d      = sel_mc;
                    q_d      = sel_mp;
                    a_d      = '0;
                    q1_d     = 1'b0;
                    cnt_d    = '0;
                    rsp_id_d = accept_id;
                    last_d   = accept_id;
                    state_d  = ST_RUN;
                end
            end

            ST_RUN: begin
                if (bypass) begin
                    rsp_y_d     = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    a_d   = a_shift;
                    q_d   = q_shift;
                    q1_d  = q1_shift;
                    cnt_d = cnt_q + CW'(1);
                    // Final step result goes straight to the output register
                    if (last_step) begin
                        rsp_y_d     = {a_shift[WIDTH-1:0], q_shift};
                        rsp_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset discards any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            q_q         <= '0;
            q1_q        <= 1'b0;
            m_q         <= '0;
            cnt_q       <= '0;
            last_q      <= 1'b1;   // makes requester 0 win the first tie
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            q_q         <= q_d;
            q1_q        <= q1_d;
            m_q         <= m_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
